array_9_port_ctrl: RTL

Sequencer and arbiter for the 256 x 86 single-port array macro (`array_9_ext`). It clears the array to zero after reset, then shares the one RW port between a read requester and a write requester under round-robin arbitration. It also returns read data with a one-cycle response strobe. It sits between the owning pipeline and the macro and is the only block that drives the macro port.

---
 rtl/array_9_pkg.sv | 33 +++
 rtl/array_9_rr_arb.sv | 39 +++
 rtl/array_9_port_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/array_9_pkg.sv
// Shared constants and types for the array_9 port controller.
// Covers the clear/run FSM, grant encoding and arbiter request indices.
package array_9_pkg;

    localparam int ARR9_DEPTH = 256;
    localparam int ARR9_WIDTH = 86;
    localparam int ARR9_LANES = 2;
    localparam int ARR9_AW    = 8;

    // Bit positions of the two requesters in the arbiter req/gnt vectors.
    localparam int ARR9_RD = 0;
    localparam int ARR9_WR = 1;

    typedef enum logic {
        INIT,
        RUN
    } arr9_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_RD,
        GNT_WR
    } arr9_gnt_t;

    function automatic arr9_gnt_t arr9_decode_gnt(input logic [1:0] gnt);
        case (gnt)
            2'b01:   return GNT_RD;
            2'b10:   return GNT_WR;
            default: return GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/array_9_rr_arb.sv
// Two-way round-robin arbiter between the read and write requesters.
// The priority bit only moves on a contended cycle, so contention alternates exactly.
module array_9_rr_arb
    import array_9_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic prio;  // 0: read wins the next tie, 1: write wins it

    // NOTE: give every combinational output a default before any branch,
    // otherwise a path that leaves it unassigned infers a latch.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (&req) begin
                gnt[ARR9_RD] = ~prio;
                gnt[ARR9_WR] = prio;
            end else begin
                gnt = req;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            prio <= 1'b0;
        end else if (en && (&req)) begin
            prio <= ~prio;
        end
    end

endmodule

// File: rtl/array_9_port_ctrl.sv
// Clears the 256x86 single-port array after reset, then arbitrates its RW port
// between one read and one write requester and returns read data one cycle later.
module array_9_port_ctrl
    import array_9_pkg::*;
#(
    parameter  int DEPTH = ARR9_DEPTH,
    parameter  int WIDTH = ARR9_WIDTH,
    parameter  int LANES = ARR9_LANES,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             rd_valid,
    output logic             rd_ready,
    input  logic [AW-1:0]    rd_addr,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [LANES-1:0] wr_mask,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             init_done,
    output logic             mem_en,
    output logic             mem_wmode,
    output logic [AW-1:0]    mem_addr,
    output logic [LANES-1:0] mem_wmask,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    arr9_state_t   state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic          rsp_valid_q;
    logic [1:0]    gnt;
    arr9_gnt_t     gnt_kind;

    // Requests are only considered once the clear has finished and reset is off.
    array_9_rr_arb u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (reset_n && (state_q == RUN)),
        .req     ({wr_valid, rd_valid}),
        .gnt     (gnt)
    );

    assign gnt_kind = arr9_decode_gnt(gnt);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= INIT;
            clr_idx_q   <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            rsp_valid_q <= (gnt_kind == GNT_RD);
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        rd_ready  = 1'b0;
        wr_ready  = 1'b0;
        mem_en    = 1'b0;
        mem_wmode = 1'b0;
        mem_addr  = '0;
        mem_wmask = '0;
        mem_wdata = '0;

        unique case (state_q)
            INIT: begin
                // The port stays quiet while reset is held, even though INIT is the reset state.
                if (reset_n) begin
                    mem_en    = 1'b1;
                    mem_wmode = 1'b1;
                    mem_addr  = clr_idx_q;
                    mem_wmask = '1;
                    clr_idx_d = clr_idx_q + AW'(1);
                    if (clr_idx_q == AW'(DEPTH - 1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rd_ready = gnt[ARR9_RD];
                wr_ready = gnt[ARR9_WR];
                unique case (gnt_kind)
                    GNT_RD: begin
                        mem_en   = 1'b1;
                        mem_addr = rd_addr;
                    end
                    GNT_WR: begin
                        mem_en    = 1'b1;
                        mem_wmode = 1'b1;
                        mem_addr  = wr_addr;
                        mem_wmask = wr_mask;
                        mem_wdata = wr_data;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign init_done = (state_q == RUN);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = mem_rdata;

endmodule
